// File: rtl/matrix_row_prefetch.sv
// -----------------------------------------------------------------------------
// matrix_row_prefetch
//
// Pixel data stage that sits between the framebuffer and the scan controller's
// shift-out path. Two 64-entry line buffers are used ping-pong: the active bank
// feeds the shift-out path while the inactive bank is filled with the next row
// pair over a req/ack memory interface.
//
// Ports:
//   clk_in           system clock, all logic on the rising edge
//   reset            synchronous, active-high
//   row_address      row pair currently being shifted out
//   column_address   column currently being shifted out
//   brightness_mask  one-hot brightness plane select, 0 blanks the outputs
//   rgb_top          {R,G,B} plane bits for row row_address
//   rgb_bottom       {R,G,B} plane bits for row row_address+16
//   mem_req          framebuffer read request
//   mem_addr         {row[3:0], col[5:0]} of the outstanding read
//   mem_ack          read accepted, mem_rdata valid in the same cycle
//   mem_rdata        [35:18] bottom pixel, [17:0] top pixel (R[17:12] G[11:6] B[5:0])
//   underrun         sticky: a row change found its row not loaded
//   mem_timeout      sticky: no mem_ack within MEM_LATENCY_MAX cycles
// -----------------------------------------------------------------------------
module matrix_row_prefetch #(
   parameter int MEM_LATENCY_MAX = 255
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [3:0]  row_address,
   input  logic [5:0]  column_address,
   input  logic [5:0]  brightness_mask,
   output logic [2:0]  rgb_top,
   output logic [2:0]  rgb_bottom,
   output logic        mem_req,
   output logic [9:0]  mem_addr,
   input  logic        mem_ack,
   input  logic [35:0] mem_rdata,
   output logic        underrun,
   output logic        mem_timeout
);

   localparam int WD_W = $clog2(MEM_LATENCY_MAX + 1);

   // DRAIN holds an aborted request until its ack arrives, then discards the data.
   typedef enum logic [1:0] {IDLE, START, REQ, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [35:0]      line_buf [2][64];
   logic [1:0]       bank_valid, valid_upd, valid_nxt;
   logic [1:0][3:0]  loaded_row, loaded_upd;
   logic             active_bank, inactive_bank;
   logic [3:0]       prev_row, pend_row, fetch_row, row_next;
   logic             pend_bank, fetch_bank;
   logic [5:0]       col;
   logic [WD_W-1:0]  wd_cnt;
   logic             row_change, fill_ack, fill_done, wd_expire, buf_we, swap_hit;
   logic [5:0]       col_q, mask_d1, mask_d2;
   logic [35:0]      pixel_q;
   logic             valid_q;
   logic [17:0]      pix_top, pix_bot;

   assign mem_req       = (state == REQ) || (state == DRAIN);
   assign mem_addr      = {fetch_row, col};
   assign inactive_bank = ~active_bank;
   assign row_next      = row_address + 4'd1;
   assign row_change    = (row_address != prev_row);
   assign fill_ack      = (state == REQ) && mem_ack;
   assign fill_done     = fill_ack && (col == 6'd63);
   assign wd_expire     = mem_req && !mem_ack && (wd_cnt == WD_W'(MEM_LATENCY_MAX - 1));
   // A mid-row ack that coincides with a row change belongs to an aborted fetch.
   assign buf_we        = fill_ack && !reset && ((col == 6'd63) || !row_change);

   // Bank bookkeeping as it stands after this cycle's fill completes, so a row
   // change landing on the final ack sees the freshly loaded bank.
   always_comb begin
      valid_upd  = bank_valid;
      loaded_upd = loaded_row;
      if (fill_done) begin
         valid_upd[fetch_bank]  = 1'b1;
         loaded_upd[fetch_bank] = fetch_row;
      end
   end

   assign swap_hit = valid_upd[inactive_bank] && (loaded_upd[inactive_bank] == row_address);

   // On any row change the bank that was active is about to be refetched (either
   // as the new prefetch target or as the underrun refill), so it goes invalid at
   // once. START invalidates its target unless a row change is re-targeting it.
   always_comb begin
      valid_nxt = valid_upd;
      if (row_change) begin
         valid_nxt[active_bank] = 1'b0;
      end else if (state == START) begin
         valid_nxt[pend_bank] = 1'b0;
      end
   end

   // Next-state logic. A row change always ends in START, but only after any
   // outstanding request has been acknowledged; the watchdog may cut it short.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (row_change) state_nxt = START;
         end
         START: begin
            state_nxt = row_change ? START : REQ;
         end
         REQ: begin
            if (wd_expire) begin
               state_nxt = row_change ? START : IDLE;
            end else if (mem_ack) begin
               if (row_change) begin
                  state_nxt = START;
               end else if (col == 6'd63) begin
                  state_nxt = (fetch_bank == active_bank) ? START : IDLE;
               end
            end else if (row_change) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (wd_expire) begin
               state_nxt = row_change ? START : IDLE;
            end else if (mem_ack) begin
               state_nxt = START;
            end
         end
         default: state_nxt = START;
      endcase
   end

   // Fetch control, bank bookkeeping, row tracking, watchdog and sticky flags.
   // pend_row/pend_bank hold the next fetch target so a draining request keeps
   // its address stable until START picks the new target up.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state       <= START;
         bank_valid  <= 2'b00;
         loaded_row  <= '0;
         active_bank <= 1'b0;
         prev_row    <= row_address;
         pend_row    <= row_address;
         pend_bank   <= 1'b0;
         fetch_row   <= 4'd0;
         fetch_bank  <= 1'b0;
         col         <= 6'd0;
         wd_cnt      <= '0;
         underrun    <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state      <= state_nxt;
         prev_row   <= row_address;
         bank_valid <= valid_nxt;
         loaded_row <= loaded_upd;

         if (row_change) begin
            pend_bank <= active_bank;
            if (swap_hit) begin
               active_bank <= inactive_bank;
               pend_row    <= row_next;
            end else begin
               underrun <= 1'b1;
               pend_row <= row_address;
            end
         end else if (fill_done && (fetch_bank == active_bank)) begin
            pend_row  <= row_next;
            pend_bank <= inactive_bank;
         end

         if (state == START) begin
            fetch_row  <= pend_row;
            fetch_bank <= pend_bank;
            col        <= 6'd0;
         end else if (fill_ack && (col != 6'd63) && !row_change) begin
            col <= col + 6'd1;
         end

         if (mem_req && !mem_ack) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end else begin
            wd_cnt <= '0;
         end

         if (wd_expire) mem_timeout <= 1'b1;
      end
   end

   // Line buffer storage; no reset so it maps onto RAM. Read and write of the
   // same entry in one cycle returns the previous contents.
   always_ff @(posedge clk_in) begin
      if (buf_we) line_buf[fetch_bank][col] <= mem_rdata;
      pixel_q <= line_buf[active_bank][col_q];
   end

   // Output pipeline: column register, then registered bank read. The mask and
   // the bank-valid flag ride along so they line up with the pixel data.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         col_q   <= 6'd0;
         mask_d1 <= 6'd0;
         mask_d2 <= 6'd0;
         valid_q <= 1'b0;
      end else begin
         col_q   <= column_address;
         mask_d1 <= brightness_mask;
         mask_d2 <= mask_d1;
         valid_q <= bank_valid[active_bank];
      end
   end

   assign pix_top = pixel_q[17:0];
   assign pix_bot = pixel_q[35:18];

   assign rgb_top    = valid_q ? {|(pix_top[17:12] & mask_d2), |(pix_top[11:6] & mask_d2),
                                  |(pix_top[5:0] & mask_d2)} : 3'b000;
   assign rgb_bottom = valid_q ? {|(pix_bot[17:12] & mask_d2), |(pix_bot[11:6] & mask_d2),
                                  |(pix_bot[5:0] & mask_d2)} : 3'b000;

endmodule

// File: tb/tb_matrix_row_prefetch.sv
// -----------------------------------------------------------------------------
// tb_matrix_row_prefetch
//
// Directed bench for matrix_row_prefetch. A memory responder answers requests
// with a fixed address-derived pixel pattern and checks each accepted address
// against a queue of expected fetch addresses. RGB expectations are queued with
// their due cycle and popped when the two-cycle output pipeline delivers them.
// -----------------------------------------------------------------------------
module tb_matrix_row_prefetch;

   logic        clk_in = 1'b0;
   logic        reset;
   logic [3:0]  row_address;
   logic [5:0]  column_address;
   logic [5:0]  brightness_mask;
   logic [2:0]  rgb_top;
   logic [2:0]  rgb_bottom;
   logic        mem_req;
   logic [9:0]  mem_addr;
   logic        mem_ack;
   logic [35:0] mem_rdata;
   logic        underrun;
   logic        mem_timeout;

   typedef struct {
      int         due;
      logic [2:0] top;
      logic [2:0] bot;
   } rgb_exp_t;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         ack_count = 0;
   int         hold_cnt = 0;
   bit         ack_enable = 1'b1;
   bit         model_valid = 1'b0;
   logic [3:0] model_row = 4'd0;
   logic [9:0] exp_addr [$];
   rgb_exp_t   rgb_q [$];

   matrix_row_prefetch #(.MEM_LATENCY_MAX(255)) dut (
      .clk_in          (clk_in),
      .reset           (reset),
      .row_address     (row_address),
      .column_address  (column_address),
      .brightness_mask (brightness_mask),
      .rgb_top         (rgb_top),
      .rgb_bottom      (rgb_bottom),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata),
      .underrun        (underrun),
      .mem_timeout     (mem_timeout)
   );

   // Free-running clock and a cycle counter used to time RGB expectations.
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Framebuffer pattern: top = {col, ~col, row}, bottom = {~col, col, col^row}.
   function automatic logic [35:0] pix_word(input logic [9:0] a);
      logic [5:0] c;
      logic [5:0] r;
      c = a[5:0];
      r = {2'b00, a[9:6]};
      return {~c, c, c ^ r, c, ~c, r};
   endfunction

   function automatic logic [2:0] plane(input logic [17:0] p, input logic [5:0] m);
      return {|(p[17:12] & m), |(p[11:6] & m), |(p[5:0] & m)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory responder: decides mem_ack just after each falling edge and checks
   // the address of every request that will be accepted on the next rising edge.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk_in);
         #1;
         if (reset !== 1'b0) begin
            mem_ack = 1'b0;
            continue;
         end
         if (!ack_enable) begin
            mem_ack = 1'b0;
         end else if (hold_cnt > 0 && mem_req) begin
            mem_ack = 1'b0;
            hold_cnt--;
         end else begin
            mem_ack = 1'b1;
         end
         mem_rdata = pix_word(mem_addr);
         if (mem_req && mem_ack) begin
            ack_count++;
            if (exp_addr.size() == 0) begin
               check("unexpected_req_addr", {22'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
               check("mem_addr", {22'd0, mem_addr}, {22'd0, exp_addr.pop_front()});
            end
         end
      end
   end

   // Run-away guard so the bench always ends.
   initial begin
      #600000;
      $display("[TB] FAIL sim_timeout: observed time %0t required finish earlier", $time);
      $fatal(1, "[TB] simulation time limit");
   end

   task automatic push_row(input logic [3:0] r);
      for (int c = 0; c < 64; c++) exp_addr.push_back({r, 6'(c)});
   endtask

   // Assert reset for three cycles, check the reset state, then release.
   task automatic do_reset(input logic [3:0] r, input bit en);
      @(negedge clk_in);
      reset       = 1'b1;
      row_address = r;
      ack_enable  = en;
      hold_cnt    = 0;
      ack_count   = 0;
      exp_addr.delete();
      repeat (3) @(negedge clk_in);
      check("reset_rgb_top", rgb_top, 0);
      check("reset_rgb_bottom", rgb_bottom, 0);
      check("reset_mem_req", mem_req, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_underrun", underrun, 0);
      check("reset_mem_timeout", mem_timeout, 0);
   endtask

   task automatic wait_queue_empty(input string tag, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (exp_addr.size() == 0) break;
         @(negedge clk_in);
      end
      check(tag, exp_addr.size(), 0);
   endtask

   task automatic wait_req(input string tag, input logic [9:0] exp, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (mem_req) break;
         @(negedge clk_in);
      end
      check(tag, {mem_req, mem_addr}, {1'b1, exp});
   endtask

   task automatic applyStimulus(input logic [5:0] c, input logic [5:0] m);
      logic [35:0] w;
      rgb_exp_t    e;
      column_address  = c;
      brightness_mask = m;
      w     = pix_word({model_row, c});
      e.due = cyc + 2;
      e.top = model_valid ? plane(w[17:0], m) : 3'b000;
      e.bot = model_valid ? plane(w[35:18], m) : 3'b000;
      rgb_q.push_back(e);
   endtask

   task automatic checkOutput();
      rgb_exp_t e;
      while (rgb_q.size() > 0 && rgb_q[0].due <= cyc) begin
         e = rgb_q.pop_front();
         check("rgb_top", rgb_top, e.top);
         check("rgb_bottom", rgb_bottom, e.bot);
      end
   endtask

   task automatic run_vector(input logic [5:0] c, input logic [5:0] m);
      @(negedge clk_in);
      checkOutput();
      applyStimulus(c, m);
   endtask

   task automatic flush_rgb();
      for (int k = 0; k < 4 && rgb_q.size() > 0; k++) begin
         @(negedge clk_in);
         checkOutput();
      end
      check("rgb_queue_drained", rgb_q.size(), 0);
   endtask

   task automatic random_sweep(input int n);
      int         sel;
      logic [5:0] m;
      for (int i = 0; i < n; i++) begin
         sel = $urandom_range(0, 6);
         m   = (sel == 6) ? 6'd0 : 6'(1 << sel);
         run_vector(6'($urandom_range(0, 63)), m);
      end
      flush_rgb();
   endtask

   initial begin
      int cnt;
      logic found;
      reset           = 1'b1;
      row_address     = 4'd0;
      column_address  = 6'd0;
      brightness_mask = 6'd0;

      // Cold start on row 0: row 0 into bank 0, then row 1 into bank 1.
      do_reset(4'd0, 1'b1);
      push_row(4'd0);
      push_row(4'd1);
      reset = 1'b0;
      wait_queue_empty("fetch_rows_0_1", 400);
      repeat (2) @(negedge clk_in);
      check("idle_mem_req", mem_req, 0);
      check("idle_underrun", underrun, 0);
      check("ack_count_128", ack_count, 128);

      // Plane extraction from bank 0 (row 0).
      model_valid = 1'b1;
      model_row   = 4'd0;
      run_vector(6'd5, 6'b000100);
      run_vector(6'd5, 6'b000010);
      run_vector(6'd5, 6'b000000);
      run_vector(6'd63, 6'b100000);
      run_vector(6'd0, 6'b000001);
      random_sweep(8);

      // Row 0 -> 1 with row 1 preloaded: swap, then prefetch row 2.
      @(negedge clk_in);
      row_address = 4'd1;
      push_row(4'd2);
      @(negedge clk_in);
      check("swap_no_underrun", underrun, 0);
      wait_req("swap_first_addr", 10'd128, 10);
      wait_queue_empty("prefetch_row_2", 200);
      model_row = 4'd1;
      random_sweep(8);

      // Row 15 -> 0 wrap: prefetch target wraps to row 1.
      do_reset(4'd15, 1'b1);
      push_row(4'd15);
      push_row(4'd0);
      reset = 1'b0;
      wait_queue_empty("fetch_rows_15_0", 400);
      @(negedge clk_in);
      row_address = 4'd0;
      push_row(4'd1);
      wait_req("wrap_first_addr", 10'd64, 10);
      wait_queue_empty("prefetch_row_1", 200);
      check("wrap_no_underrun", underrun, 0);
      model_row = 4'd0;
      random_sweep(6);

      // Abort mid-prefetch: row changes to the row being fetched at col 30 while
      // the ack is withheld for three cycles.
      @(negedge clk_in);
      row_address = 4'd1;
      push_row(4'd2);
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk_in);
         if (mem_req && mem_addr == 10'd158) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_col_30", found, 1);
      hold_cnt    = 3;
      row_address = 4'd2;
      while (exp_addr.size() > 1) void'(exp_addr.pop_back());
      push_row(4'd2);
      push_row(4'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         check("abort_req_held", mem_req, 1);
         check("abort_addr_held", mem_addr, 10'd158);
      end
      check("abort_underrun", underrun, 1);
      wait_queue_empty("refetch_rows_2_3", 400);
      model_row = 4'd2;
      random_sweep(8);

      // Memory never answers: watchdog expires after 255 request cycles.
      do_reset(4'd5, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_in);
         if (mem_req) break;
      end
      cnt = 0;
      while (mem_req && cnt < 1000) begin
         cnt++;
         @(negedge clk_in);
      end
      check("wd_req_cycles", cnt, 255);
      check("wd_mem_timeout", mem_timeout, 1);
      check("wd_mem_req_low", mem_req, 0);
      check("wd_no_underrun", underrun, 0);
      model_valid = 1'b0;
      model_row   = 4'd5;
      run_vector(6'd3, 6'b000001);
      run_vector(6'd10, 6'b100000);
      run_vector(6'd5, 6'b000100);
      flush_rgb();

      // The next row change retries with a responsive memory.
      @(negedge clk_in);
      ack_enable  = 1'b1;
      row_address = 4'd6;
      push_row(4'd6);
      push_row(4'd7);
      wait_queue_empty("retry_rows_6_7", 400);
      check("retry_underrun", underrun, 1);
      check("retry_timeout_sticky", mem_timeout, 1);
      model_valid = 1'b1;
      model_row   = 4'd6;
      random_sweep(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
